pipeline_hazard_ctrl: RTL and testbench

Parametrised hazard and pipeline-control unit for the 5-stage MIPS core. It sits beside the main decoder. It takes register-use information from ID and producer information from EXE/MEM. It generates per-stage enable/reset, load-use and full-interlock stalls, a counter-based branch flush, and registered EXE-stage operand forwarding selects. It adds a memory-busy freeze, which the previous controller did not have.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 12 +
 rtl/pipeline_hazard_ctrl_hazard_match.sv | 27 ++
 rtl/pipeline_hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the hazard / pipeline-control unit.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,   // operand from register file
        FWD_MEM = 2'b01,   // MEM-stage ALU result
        FWD_WB  = 2'b10    // WB-stage write data
    } fwd_sel_e;

    localparam int GPR_ZERO = 0;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_match.sv
// Per-operand dependency comparator against the EXE and MEM producers.
module hazard_match
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_src_used,
    input  logic [REG_ADDR_W-1:0] i_src_addr,
    input  logic                  i_exe_wb_wen,
    input  logic [REG_ADDR_W-1:0] i_exe_wb_addr,
    input  logic                  i_exe_mem_ren,
    input  logic                  i_mem_wb_wen,
    input  logic [REG_ADDR_W-1:0] i_mem_wb_addr,
    output logic                  o_match_exe,
    output logic                  o_match_mem,
    output logic                  o_is_load
);

    logic w_live;

    // $0 is hard-wired, so it never creates a dependency.
    assign w_live      = i_src_used && (i_src_addr != REG_ADDR_W'(GPR_ZERO));
    assign o_match_exe = w_live && i_exe_wb_wen && (i_exe_wb_addr == i_src_addr);
    assign o_match_mem = w_live && i_mem_wb_wen && (i_mem_wb_addr == i_src_addr);
    assign o_is_load   = o_match_exe && i_exe_mem_ren;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard detection, stage enable/clear generation, branch flush counter and
// EXE forwarding selects. Define FORWARDING_EN for bypassing; otherwise full interlock.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int BR_FLUSH   = 3,
    parameter int CNT_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic                  id_is_branch,
    input  logic                  exe_wb_wen,
    input  logic [REG_ADDR_W-1:0] exe_wb_addr,
    input  logic                  exe_mem_ren,
    input  logic                  mem_wb_wen,
    input  logic [REG_ADDR_W-1:0] mem_wb_addr,
    input  logic                  mem_busy,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  if_en,
    output logic                  id_en,
    output logic                  exe_en,
    output logic                  mem_en,
    output logic                  wb_en,
    output logic                  if_rst,
    output logic                  id_rst,
    output logic                  exe_rst,
    output logic                  mem_rst,
    output logic                  wb_rst,
    output logic                  stall_load
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BR_FLUSH - 1);

    logic             w_rs_exe, w_rs_mem, w_rs_ld;
    logic             w_rt_exe, w_rt_mem, w_rt_ld;
    logic             w_hazard, w_br_new, w_cnt_load;
    logic [CNT_W-1:0] r_cnt;

    hazard_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_rs (
        .i_src_used   (id_rs_used),
        .i_src_addr   (id_rs_addr),
        .i_exe_wb_wen (exe_wb_wen),
        .i_exe_wb_addr(exe_wb_addr),
        .i_exe_mem_ren(exe_mem_ren),
        .i_mem_wb_wen (mem_wb_wen),
        .i_mem_wb_addr(mem_wb_addr),
        .o_match_exe  (w_rs_exe),
        .o_match_mem  (w_rs_mem),
        .o_is_load    (w_rs_ld)
    );

    hazard_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_rt (
        .i_src_used   (id_rt_used),
        .i_src_addr   (id_rt_addr),
        .i_exe_wb_wen (exe_wb_wen),
        .i_exe_wb_addr(exe_wb_addr),
        .i_exe_mem_ren(exe_mem_ren),
        .i_mem_wb_wen (mem_wb_wen),
        .i_mem_wb_addr(mem_wb_addr),
        .o_match_exe  (w_rt_exe),
        .o_match_mem  (w_rt_mem),
        .o_is_load    (w_rt_ld)
    );

`ifdef FORWARDING_EN
    assign w_hazard = w_rs_ld || w_rt_ld;
`else
    // is_load is a subset of match_exe; OR-ing it in keeps the expression identical.
    assign w_hazard = w_rs_ld || w_rt_ld || w_rs_exe || w_rs_mem || w_rt_exe || w_rt_mem;
`endif

    // A branch is only recognised when no flush is already running.
    assign w_br_new   = id_valid && id_is_branch && (r_cnt == '0);
    assign w_cnt_load = !mem_busy && !w_hazard && w_br_new;

    always_comb begin
        if_en      = 1'b1;
        id_en      = 1'b1;
        exe_en     = 1'b1;
        mem_en     = 1'b1;
        wb_en      = 1'b1;
        if_rst     = 1'b0;
        id_rst     = 1'b0;
        exe_rst    = 1'b0;
        mem_rst    = 1'b0;
        wb_rst     = 1'b0;
        stall_load = 1'b0;
        if (rst) begin
            {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = 5'b11111;
        end else if (mem_busy) begin
            {if_en, id_en, exe_en, mem_en, wb_en} = 5'b00000;
        end else if (w_hazard) begin
            if_en      = 1'b0;
            id_en      = 1'b0;
            exe_rst    = 1'b1;
            stall_load = 1'b1;
        end else if (w_br_new || (r_cnt != '0)) begin
            id_rst = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!mem_busy) begin
            if (w_cnt_load)
                r_cnt <= CNT_LOAD;
            else if (r_cnt != '0)
                r_cnt <= r_cnt - CNT_W'(1);
        end
    end

`ifdef FORWARDING_EN
    logic [1:0] w_fwd_a, w_fwd_b, r_fwd_a, r_fwd_b;

    // EXE producer will be in MEM when this instruction reaches EXE.
    assign w_fwd_a = w_rs_exe ? FWD_MEM : (w_rs_mem ? FWD_WB : FWD_REG);
    assign w_fwd_b = w_rt_exe ? FWD_MEM : (w_rt_mem ? FWD_WB : FWD_REG);

    always_ff @(posedge clk) begin
        if (exe_rst) begin
            r_fwd_a <= FWD_REG;
            r_fwd_b <= FWD_REG;
        end else if (exe_en) begin
            r_fwd_a <= w_fwd_a;
            r_fwd_b <= w_fwd_b;
        end
    end

    assign fwd_a_sel = r_fwd_a;
    assign fwd_b_sel = r_fwd_b;
`else
    assign fwd_a_sel = FWD_REG;
    assign fwd_b_sel = FWD_REG;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; FORWARDING_EN selects the bypass scenarios.
module tb_pipeline_hazard_ctrl;

    localparam int AW = 5;

    // {if,id,exe,mem,wb}_en, {if,id,exe,mem,wb}_rst, stall_load
    localparam logic [10:0] C_NORM  = 11'b11111_00000_0;
    localparam logic [10:0] C_RST   = 11'b11111_11111_0;
    localparam logic [10:0] C_BUSY  = 11'b00000_00000_0;
    localparam logic [10:0] C_STALL = 11'b00111_00100_1;
    localparam logic [10:0] C_FLUSH = 11'b11111_01000_0;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_rs_used, id_rt_used, id_is_branch;
    logic [AW-1:0] id_rs_addr, id_rt_addr, exe_wb_addr, mem_wb_addr;
    logic          exe_wb_wen, exe_mem_ren, mem_wb_wen, mem_busy;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic          if_en, id_en, exe_en, mem_en, wb_en;
    logic          if_rst, id_rst, exe_rst, mem_rst, wb_rst, stall_load;
    logic [10:0]   ctl;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_ADDR_W(AW), .BR_FLUSH(3), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_is_branch(id_is_branch),
        .exe_wb_wen(exe_wb_wen), .exe_wb_addr(exe_wb_addr), .exe_mem_ren(exe_mem_ren),
        .mem_wb_wen(mem_wb_wen), .mem_wb_addr(mem_wb_addr), .mem_busy(mem_busy),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .if_en(if_en), .id_en(id_en), .exe_en(exe_en), .mem_en(mem_en), .wb_en(wb_en),
        .if_rst(if_rst), .id_rst(id_rst), .exe_rst(exe_rst), .mem_rst(mem_rst), .wb_rst(wb_rst),
        .stall_load(stall_load)
    );

    assign ctl = {if_en, id_en, exe_en, mem_en, wb_en,
                  if_rst, id_rst, exe_rst, mem_rst, wb_rst, stall_load};

    task automatic idle_inputs();
        id_valid = 1'b1; id_rs_used = 1'b0; id_rt_used = 1'b0; id_is_branch = 1'b0;
        id_rs_addr = '0; id_rt_addr = '0;
        exe_wb_wen = 1'b0; exe_wb_addr = '0; exe_mem_ren = 1'b0;
        mem_wb_wen = 1'b0; mem_wb_addr = '0; mem_busy = 1'b0;
    endtask

    // Inputs change just after a rising edge; checks happen at the falling edge.
    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1; id_is_branch = 1'b1; mem_busy = 1'b1;
        #1;
        @(negedge clk);
        n_vec++;
        if (ctl !== C_RST) begin n_err++; $display("FAIL reset_busy ctl got %b want %b", ctl, C_RST); end
        next_cycle();
        mem_busy = 1'b0;
        @(negedge clk);
        n_vec++;
        if (ctl !== C_RST) begin n_err++; $display("FAIL reset ctl got %b want %b", ctl, C_RST); end
        n_vec++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
            n_err++; $display("FAIL reset_fwd got %b want 0000", {fwd_a_sel, fwd_b_sel});
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (ctl !== C_FLUSH) begin n_err++; $display("FAIL post_reset_branch ctl got %b want %b", ctl, C_FLUSH); end
        next_cycle();
        id_is_branch = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (ctl !== ((i < 2) ? C_FLUSH : C_NORM)) begin
                n_err++; $display("FAIL post_reset_count[%0d] ctl got %b want %b", i, ctl, (i < 2) ? C_FLUSH : C_NORM);
            end
            next_cycle();
        end
    endtask

    task automatic test_branch_flush();
        idle_inputs();
        id_is_branch = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++;
            if (ctl !== ((i < 3) ? C_FLUSH : C_NORM)) begin
                n_err++; $display("FAIL branch_flush[%0d] ctl got %b want %b", i, ctl, (i < 3) ? C_FLUSH : C_NORM);
            end
            next_cycle();
            id_is_branch = 1'b0;
        end
    endtask

    task automatic test_flush_busy();
        idle_inputs();
        id_is_branch = 1'b1;
        next_cycle();                 // counter loads 2
        id_is_branch = 1'b0;
        next_cycle();                 // counter now 1
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++;
            if (ctl !== C_BUSY) begin n_err++; $display("FAIL flush_busy[%0d] ctl got %b want %b", i, ctl, C_BUSY); end
            next_cycle();
        end
        mem_busy = 1'b0;
        @(negedge clk);
        n_vec++;
        if (ctl !== C_FLUSH) begin n_err++; $display("FAIL flush_resume ctl got %b want %b", ctl, C_FLUSH); end
        next_cycle();
        @(negedge clk);
        n_vec++;
        if (ctl !== C_NORM) begin n_err++; $display("FAIL flush_done ctl got %b want %b", ctl, C_NORM); end
        next_cycle();
    endtask

    task automatic test_hazard_over_branch();
        idle_inputs();
        exe_wb_wen = 1'b1; exe_wb_addr = 5'd3; exe_mem_ren = 1'b1;
        id_rs_used = 1'b1; id_rs_addr = 5'd3; id_is_branch = 1'b1;
        @(negedge clk);
        n_vec++;
        if (ctl !== C_STALL) begin n_err++; $display("FAIL hazard_branch ctl got %b want %b", ctl, C_STALL); end
        next_cycle();
        exe_wb_wen = 1'b0; exe_mem_ren = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++;
            if (ctl !== ((i < 3) ? C_FLUSH : C_NORM)) begin
                n_err++; $display("FAIL hazard_branch_flush[%0d] ctl got %b want %b", i, ctl, (i < 3) ? C_FLUSH : C_NORM);
            end
            next_cycle();
            id_is_branch = 1'b0;
        end
    endtask

`ifdef FORWARDING_EN
    task automatic test_forward_alu();
        idle_inputs();
        exe_wb_wen = 1'b1; exe_wb_addr = 5'd3;
        id_rs_used = 1'b1; id_rs_addr = 5'd3;
        @(negedge clk);
        n_vec++;
        if (ctl !== C_NORM) begin n_err++; $display("FAIL fwd_alu ctl got %b want %b", ctl, C_NORM); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_vec++;
        if (fwd_a_sel !== 2'b01) begin n_err++; $display("FAIL fwd_alu_sel got %b want 01", fwd_a_sel); end
        next_cycle();
    endtask

    task automatic test_load_use();
        idle_inputs();
        exe_wb_wen = 1'b1; exe_wb_addr = 5'd5; exe_mem_ren = 1'b1;
        id_rt_used = 1'b1; id_rt_addr = 5'd5;
        @(negedge clk);
        n_vec++;
        if (ctl !== C_STALL) begin n_err++; $display("FAIL load_use ctl got %b want %b", ctl, C_STALL); end
        next_cycle();
        exe_wb_wen = 1'b0; exe_mem_ren = 1'b0;
        mem_wb_wen = 1'b1; mem_wb_addr = 5'd5;
        @(negedge clk);
        n_vec++;
        if (fwd_b_sel !== 2'b00) begin n_err++; $display("FAIL load_use_bubble_sel got %b want 00", fwd_b_sel); end
        n_vec++;
        if (ctl !== C_NORM) begin n_err++; $display("FAIL load_use_release ctl got %b want %b", ctl, C_NORM); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_vec++;
        if (fwd_b_sel !== 2'b10) begin n_err++; $display("FAIL load_use_sel got %b want 10", fwd_b_sel); end
        next_cycle();
    endtask
`else
    task automatic test_interlock();
        idle_inputs();
        mem_wb_wen = 1'b1; mem_wb_addr = 5'd7;
        id_rs_used = 1'b1; id_rs_addr = 5'd7;
        @(negedge clk);
        n_vec++;
        if (ctl !== C_STALL) begin n_err++; $display("FAIL interlock_mem ctl got %b want %b", ctl, C_STALL); end
        n_vec++;
        if (fwd_a_sel !== 2'b00) begin n_err++; $display("FAIL interlock_fwd got %b want 00", fwd_a_sel); end
        next_cycle();
        idle_inputs();
        exe_wb_wen = 1'b1; exe_wb_addr = 5'd9;
        id_rt_used = 1'b1; id_rt_addr = 5'd9;
        @(negedge clk);
        n_vec++;
        if (ctl !== C_STALL) begin n_err++; $display("FAIL interlock_exe_rt ctl got %b want %b", ctl, C_STALL); end
        id_rt_used = 1'b0;
        #1;
        n_vec++;
        if (ctl !== C_NORM) begin n_err++; $display("FAIL interlock_rt_unused ctl got %b want %b", ctl, C_NORM); end
        next_cycle();
        idle_inputs();
        mem_wb_wen = 1'b1; mem_wb_addr = 5'd0;
        exe_wb_wen = 1'b1; exe_wb_addr = 5'd0;
        id_rs_used = 1'b1; id_rs_addr = 5'd0;
        @(negedge clk);
        n_vec++;
        if (ctl !== C_NORM) begin n_err++; $display("FAIL interlock_zero ctl got %b want %b", ctl, C_NORM); end
        id_rs_addr = 5'd1;
        #1;
        n_vec++;
        if (ctl !== C_NORM) begin n_err++; $display("FAIL interlock_addr_diff ctl got %b want %b", ctl, C_NORM); end
        next_cycle();
    endtask
`endif

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_branch_flush();
        test_flush_busy();
        test_hazard_over_branch();
`ifdef FORWARDING_EN
        test_forward_alu();
        test_load_use();
`else
        test_interlock();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
